dstack_mc: RTL and testbench
============================

Name: dstack_mc

Overview:
Multi-context, parametrised data stack for core0. It generalises the single-context data stack to CONTEXTS independent stacks. It adds push-twice, depth reporting, underflow detection, and sticky per-context overflow/underflow flags. The core selects a context with ctx; the top three elements of that context, plus one randomly addressed element, are always visible combinationally for ALU operand fetch and rotate/copy.

Parameters:
WIDTH, 32, element width in bits
DEPTH, 65, max elements per context, top included
DEPTH_MAG, 7, width of depth count; must satisfy 2^DEPTH_MAG > DEPTH
CONTEXTS, 4, number of independent stacks
CTX_MAG, 2, ctx select width; 2^CTX_MAG >= CONTEXTS
ROT_MAG, 6, rot_addr width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all contexts
ctx  in  CTX_MAG  selected context for outputs and for this cycle's operation
clear_ctx  in  1  empty the selected context and clear its flags
movement  in  3  0 nothing, 1 push once, 2 pop once, 3 pop twice, 4 push twice; 5-7 treated as nothing
next_top  in  WIDTH  new top value for any non-nothing movement or rotate
next_second  in  WIDTH  new second value, push twice only
rot_addr  in  ROT_MAG  element index for rot_val/rotate; 0 = second, 1 = third, ...
rotate  in  1  rotate the addressed element to top
top, second, third  out  WIDTH  depth-0/1/2 elements of ctx; 0 if not present
rot_val  out  WIDTH  element at depth rot_addr+1 of ctx; 0 if not present
depth  out  DEPTH_MAG  element count of ctx
empty, full  out  1  depth==0, depth==DEPTH
overflow, underflow  out  1  sticky flags of ctx

Behaviour:
- All outputs are combinational from state, indexed by the current ctx.
- Reset: every context has depth 0 and both flags 0, so outputs read 0/empty=1. Reset overrides clear_ctx and any operation. Element storage is not cleared.
- Priority per cycle: reset > clear_ctx > operation. clear_ctx sets depth[ctx]=0 and both flags[ctx]=0; the operation is ignored that cycle.
- An operation applies only to ctx; other contexts hold. Single-cycle latency: results are visible right after the edge.
- Let d = depth[ctx] and E[i] = element at depth i.
  - Push once, requires d<DEPTH: E0=next_top, E(i+1)=old E(i), d+1.
  - Push twice, requires d<=DEPTH-2: E0=next_top, E1=next_second, E(i+2)=old E(i), d+2.
  - Pop once, requires d>=1: old E0 and E1 are consumed and next_top becomes E0; E(i)=old E(i+1) for i>=1; d-1.
  - Pop twice, requires d>=2: E0=next_top, E(i)=old E(i+2) for i>=1; d-2.
  - If the resulting d is 0, the written top is discarded.
  - Nothing: hold.
- Copy has no special port. It is push once with next_top driven from rot_val.
- Rotate is honoured only when movement=nothing; with any other movement it is ignored. Let k=rot_addr+1; rotate requires k<d.
  - Element k is removed.
  - E1=old E0.
  - E(i)=old E(i-1) for 2<=i<=k.
  - Elements below k are unchanged.
  - E0=next_top (normally driven from rot_val).
  - d is unchanged.
- Violations:
  - Push with insufficient room sets overflow[ctx].
  - Pop or rotate with insufficient elements sets underflow[ctx].
  - A violating operation is dropped entirely: no element or depth change.
  - Flags stay set until reset or clear_ctx.
- rot_addr+1 >= d: rot_val reads 0.
- ctx >= CONTEXTS: outputs read 0, and operations and clear_ctx are ignored.
- ctx may change every cycle; no state is lost on a context switch.

Test Plan:
- ctx0: push 2, push 8 → top 8, second 2, depth 2. Pop once with next_top=second → top 2, depth 1. Push 11, 12, then pop twice with next_top=third → top 2, depth 1.
- ctx0 stack 2,33,57,77,79 (top 79). Rotate with rot_addr=1, next_top=rot_val → top 57, second 79, third 77, depth 5. Pop twice with next_top=third → top 77, second 33. Push with next_top=rot_val, rot_addr=1 → top 2, second 77.
- Context isolation: push 5 to ctx1, push 9 to ctx2, then select ctx1 → top 5, depth 1. Select ctx2 → top 9. Select ctx3 → empty=1, top 0.
- Overflow: reset, then 65 pushes to ctx0 → full=1, overflow=0. 66th push → overflow=1, depth 65, top unchanged. Push twice at depth 64 → dropped, overflow=1. clear_ctx → depth 0, overflow 0.
- Underflow: after reset, pop once on ctx0 → underflow=1, depth 0. At depth 1, pop twice → dropped. Rotate rot_addr=1 at depth 2 → dropped, underflow=1. Other contexts' flags stay 0.
- Push twice 3/4 onto depth-1 stack [7] → top 3, second 4, third 7, depth 3. Reset asserted simultaneously with a push → depth 0, empty=1.

Source files
------------

// File: rtl/dstack_mc.sv
// Multi-context data stack. Ops on the selected context land at the next edge; all reads are combinational.
// There is no backpressure: an illegal push/pop/rotate is dropped and sets that context's sticky flag.
module dstack_mc #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 65,
  parameter int DEPTH_MAG = 7,
  parameter int CONTEXTS  = 4,
  parameter int CTX_MAG   = 2,
  parameter int ROT_MAG   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CTX_MAG-1:0]   ctx,
  input  logic                 clear_ctx,
  input  logic [2:0]           movement,
  input  logic [WIDTH-1:0]     next_top,
  input  logic [WIDTH-1:0]     next_second,
  input  logic [ROT_MAG-1:0]   rot_addr,
  input  logic                 rotate,
  output logic [WIDTH-1:0]     top,
  output logic [WIDTH-1:0]     second,
  output logic [WIDTH-1:0]     third,
  output logic [WIDTH-1:0]     rot_val,
  output logic [DEPTH_MAG-1:0] depth,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);

  // Elements are stored bottom-up: E(i) lives at index d-1-i.
  logic [WIDTH-1:0]     mem     [CONTEXTS][DEPTH];
  logic [DEPTH_MAG-1:0] depth_q [CONTEXTS];
  logic [CONTEXTS-1:0]  ovf_q, unf_q;

  logic                 ctx_ok;
  logic [DEPTH_MAG-1:0] d, new_d, new_top_idx;
  logic [DEPTH_MAG:0]   k_w;
  logic [DEPTH_MAG-1:0] rot_lo;
  logic                 rot_ok;
  logic                 mv_push1, mv_push2, mv_pop1, mv_pop2, mv_rot, is_op;
  logic                 ovf_viol, unf_viol, op_ok;

  always_comb begin
    ctx_ok   = ({1'b0, ctx} < (CTX_MAG+1)'(CONTEXTS));
    d        = ctx_ok ? depth_q[ctx] : '0;
    mv_push1 = (movement == 3'd1);
    mv_pop1  = (movement == 3'd2);
    mv_pop2  = (movement == 3'd3);
    mv_push2 = (movement == 3'd4);
    // Rotate only rides on a "nothing" movement (0 and the unused codes 5-7).
    mv_rot   = rotate && !(mv_push1 || mv_pop1 || mv_pop2 || mv_push2);
    is_op    = mv_push1 || mv_pop1 || mv_pop2 || mv_push2 || mv_rot;
    k_w      = (DEPTH_MAG+1)'(rot_addr) + (DEPTH_MAG+1)'(1);
    rot_ok   = (k_w < {1'b0, d});
    rot_lo   = d - DEPTH_MAG'(1) - DEPTH_MAG'(k_w);

    ovf_viol = (mv_push1 && (d >= DEPTH_MAG'(DEPTH))) ||
               (mv_push2 && (d > DEPTH_MAG'(DEPTH - 2)));
    unf_viol = (mv_pop1 && (d < DEPTH_MAG'(1))) ||
               (mv_pop2 && (d < DEPTH_MAG'(2))) ||
               (mv_rot && !rot_ok);
    op_ok    = ctx_ok && !reset && !clear_ctx && is_op && !ovf_viol && !unf_viol;

    new_d = d;
    if (mv_push1)      new_d = d + DEPTH_MAG'(1);
    else if (mv_push2) new_d = d + DEPTH_MAG'(2);
    else if (mv_pop1)  new_d = d - DEPTH_MAG'(1);
    else if (mv_pop2)  new_d = d - DEPTH_MAG'(2);
    new_top_idx = new_d - DEPTH_MAG'(1);
  end

  always_comb begin
    top     = '0;
    second  = '0;
    third   = '0;
    rot_val = '0;
    if (d >= DEPTH_MAG'(1)) top    = mem[ctx][d - DEPTH_MAG'(1)];
    if (d >= DEPTH_MAG'(2)) second = mem[ctx][d - DEPTH_MAG'(2)];
    if (d >= DEPTH_MAG'(3)) third  = mem[ctx][d - DEPTH_MAG'(3)];
    if (rot_ok)             rot_val = mem[ctx][rot_lo];
  end

  assign depth     = d;
  assign empty     = (d == '0);
  assign full      = (d == DEPTH_MAG'(DEPTH));
  assign overflow  = ctx_ok && ovf_q[ctx];
  assign underflow = ctx_ok && unf_q[ctx];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CONTEXTS; c++) depth_q[c] <= '0;
      ovf_q <= '0;
      unf_q <= '0;
    end else if (ctx_ok) begin
      if (clear_ctx) begin
        depth_q[ctx] <= '0;
        ovf_q[ctx]   <= 1'b0;
        unf_q[ctx]   <= 1'b0;
      end else begin
        if (ovf_viol) ovf_q[ctx] <= 1'b1;
        if (unf_viol) unf_q[ctx] <= 1'b1;
        if (op_ok)    depth_q[ctx] <= new_d;
      end
    end
  end

  // Storage is never reset; depth alone decides what is visible.
  always_ff @(posedge clk) begin
    if (op_ok) begin
      if (new_d != '0) mem[ctx][new_top_idx] <= next_top;
      if (mv_push2)    mem[ctx][d] <= next_second;
      if (mv_rot) begin
        for (int p = 0; p < DEPTH - 1; p++) begin
          if (DEPTH_MAG'(p) >= rot_lo && DEPTH_MAG'(p) < d - DEPTH_MAG'(1))
            mem[ctx][p] <= mem[ctx][p + 1];
        end
      end
    end
  end

endmodule

// File: tb/tb_dstack_mc.sv
// Table-driven bench for dstack_mc with an expected-result queue checked one edge after each drive.
module tb_dstack_mc;
  logic        clk = 1'b0;
  logic        reset, clear_ctx, rotate;
  logic [1:0]  ctx;
  logic [2:0]  movement;
  logic [31:0] next_top, next_second;
  logic [5:0]  rot_addr;
  logic [31:0] top, second, third, rot_val;
  logic [6:0]  depth;
  logic        empty, full, overflow, underflow;

  dstack_mc dut (
    .clk(clk), .reset(reset), .ctx(ctx), .clear_ctx(clear_ctx), .movement(movement),
    .next_top(next_top), .next_second(next_second), .rot_addr(rot_addr), .rotate(rotate),
    .top(top), .second(second), .third(third), .rot_val(rot_val), .depth(depth),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  ctx;
    logic        clr;
    logic [2:0]  mv;
    logic [31:0] nt, ns;
    logic [5:0]  ra;
    logic        rot;
    logic [31:0] e_top, e_sec, e_thr, e_rv;
    logic [6:0]  e_d;
    logic        e_ovf, e_unf;
  } vec_t;

  typedef logic [138:0] obs_t;

  obs_t sb[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(int rst, int c, int clr, int mv, int nt, int ns, int ra, int rot,
                              int et, int es, int eth, int erv, int ed, int eo, int eu);
    vec_t v;
    v.rst = 1'(rst);  v.ctx = 2'(c);   v.clr = 1'(clr); v.mv = 3'(mv);
    v.nt  = 32'(nt);  v.ns  = 32'(ns); v.ra  = 6'(ra);  v.rot = 1'(rot);
    v.e_top = 32'(et); v.e_sec = 32'(es); v.e_thr = 32'(eth); v.e_rv = 32'(erv);
    v.e_d = 7'(ed); v.e_ovf = 1'(eo); v.e_unf = 1'(eu);
    return v;
  endfunction

  function automatic obs_t expect_of(vec_t v);
    return {v.e_top, v.e_sec, v.e_thr, v.e_rv, v.e_d, (v.e_d == 7'd0), (v.e_d == 7'd65),
            v.e_ovf, v.e_unf};
  endfunction

  task automatic step(input vec_t v, input string name);
    obs_t got, want;
    reset = v.rst; ctx = v.ctx; clear_ctx = v.clr; movement = v.mv;
    next_top = v.nt; next_second = v.ns; rot_addr = v.ra; rotate = v.rot;
    sb.push_back(expect_of(v));
    @(posedge clk);
    #1;
    got  = {top, second, third, rot_val, depth, empty, full, overflow, underflow};
    want = sb.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ctx = '0; clear_ctx = 1'b0; movement = '0;
    next_top = '0; next_second = '0; rot_addr = '0; rotate = 1'b0;
    //           rst c clr mv nt ns ra rot | top sec thr rv d ovf unf
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  2, 0, 0, 0,   2,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  8, 0, 0, 0,   8,  2,  0,  2, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2,  2, 0, 0, 0,   2,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 11, 0, 0, 0,  11,  2,  0,  2, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 12, 0, 0, 0,  12, 11,  2, 11, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3,  2, 0, 0, 0,   2,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 33, 0, 0, 0,  33,  2,  0,  2, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 57, 0, 0, 0,  57, 33,  2, 33, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 77, 0, 1, 0,  77, 57, 33, 33, 4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 79, 0, 1, 0,  79, 77, 57, 57, 5, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 57, 0, 1, 1,  57, 79, 77, 77, 5, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3, 77, 0, 1, 0,  77, 33,  2,  2, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1,  2, 0, 1, 0,   2, 77, 33, 33, 4, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1,  5, 0, 0, 0,   5,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 1,  9, 0, 0, 0,   9,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0,   5,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0,  0, 0, 0, 0,   9,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0,  0, 0, 0, 0,   0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,   2, 77, 33, 77, 4, 0, 0));
    tbl.push_back(mk(0, 3, 0, 1,  7, 0, 1, 0,   7,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 3, 0, 4,  3, 4, 1, 0,   3,  4,  7,  7, 3, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0,  4, 0, 0, 1,   4,  3,  7,  3, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0,   0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 2,  0, 0, 0, 0,   0,  0,  0,  0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1,  1, 0, 0, 0,   1,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3,  0, 0, 0, 0,   1,  0,  0,  0, 1, 0, 1));
    tbl.push_back(mk(0, 2, 0, 1,  5, 0, 0, 0,   5,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0, 2, 0, 1,  6, 0, 1, 0,   6,  5,  0,  0, 2, 0, 0));
    tbl.push_back(mk(0, 2, 0, 0,  0, 0, 1, 1,   6,  5,  0,  0, 2, 0, 1));
    tbl.push_back(mk(0, 3, 0, 0,  0, 0, 0, 0,   0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 2, 1, 1,  9, 0, 0, 0,   0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,   0,  0,  0,  0, 0, 0, 1));
    tbl.push_back(mk(0, 3, 0, 1, 10, 0, 0, 1,  10,  0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(1, 3, 0, 1, 11, 0, 0, 0,   0,  0,  0,  0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Fill ctx0 to the limit; rot_addr=63 reaches the bottom only when full.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovf_reset");
    for (int i = 0; i < 65; i++) begin
      step(mk(0, 0, 0, 1, 100 + i, 0, 63, 0,
              100 + i, (i >= 1) ? 99 + i : 0, (i >= 2) ? 98 + i : 0,
              (i == 64) ? 100 : 0, i + 1, 0, 0),
           $sformatf("fill%0d", i));
    end
    step(mk(0, 0, 0, 1, 999, 0, 63, 0, 164, 163, 162, 100, 65, 1, 0), "push_full");
    step(mk(0, 0, 0, 2, 163, 0, 63, 0, 163, 162, 161, 0, 64, 1, 0), "pop_to_64");
    step(mk(0, 0, 0, 4, 1, 2, 63, 0, 163, 162, 161, 0, 64, 1, 0), "push2_at_64");
    step(mk(0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "clear_ctx");
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "other_ctx_clean");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
